// File: rtl/ifetch_unit.sv
// ifetch_unit: instruction fetch front end.
// It keeps at most one memory request outstanding and feeds a 2-entry
// instruction buffer toward decode. A redirect (flush) empties the buffer
// and drops or discards whatever is still in flight.
// Optional feature macro: IF_ALIGN_CHK_EN. When it is defined, a misaligned
// PC is not fetched. Instead it produces a buffered address-error entry.
module ifetch_unit (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] pc,
    output logic        pc_adv,
    input  logic        flush,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        fetch_adel
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

    state_t      r_state;
    state_t      w_stateNext;
    logic [31:0] r_tag;
    logic [31:0] r_instMem [2];
    logic [31:0] r_pcMem [2];
    logic        r_wrPtr;
    logic        r_rdPtr;
    logic [1:0]  r_count;

    logic        w_push;
    logic        w_pop;
    logic        w_slotFree;
    logic        w_slotAfterPush;
    logic        w_req;
    logic        w_adv;
    logic [31:0] w_pushInst;
    logic [31:0] w_pushPc;

`ifdef IF_ALIGN_CHK_EN
    logic        r_adelMem [2];
    logic        r_adelHalt;
    logic        w_pushAdel;
    logic        w_misaligned;

    assign w_misaligned = (pc[1:0] != 2'b00);
    assign imem_addr    = pc;
    assign fetch_adel   = inst_valid & r_adelMem[r_rdPtr];
`else
    assign imem_addr    = {pc[31:2], 2'b00};
    assign fetch_adel   = 1'b0;
`endif

    assign inst_valid      = (r_count != 2'd0);
    assign w_pop           = inst_valid & inst_ready;
    assign w_slotFree      = (r_count != 2'd2);
    assign w_slotAfterPush = (r_count == 2'd0) | w_pop;
    assign inst            = inst_valid ? r_instMem[r_rdPtr] : 32'h0;
    assign inst_pc         = inst_valid ? r_pcMem[r_rdPtr] : 32'h0;
    assign imem_req        = w_req & ~clr;
    assign pc_adv          = w_adv & ~clr;

    // Next-state and request/push decisions; a flush always wins over a push.
    // A response landing in the same cycle as a flush in WAIT retires the
    // outstanding request, so there is nothing left for DROP to wait for.
    always_comb begin
        w_stateNext = r_state;
        w_req       = 1'b0;
        w_adv       = 1'b0;
        w_push      = 1'b0;
        w_pushInst  = imem_rdata;
        w_pushPc    = r_tag;
`ifdef IF_ALIGN_CHK_EN
        w_pushAdel  = 1'b0;
`endif
        case (r_state)
            IDLE: begin
`ifdef IF_ALIGN_CHK_EN
                if (!flush && w_slotFree && !r_adelHalt) begin
                    if (w_misaligned) begin
                        w_push     = 1'b1;
                        w_pushInst = 32'h0;
                        w_pushPc   = pc;
                        w_pushAdel = 1'b1;
                    end else begin
                        w_stateNext = REQ;
                    end
                end
`else
                if (!flush && w_slotFree) begin
                    w_stateNext = REQ;
                end
`endif
            end
            REQ: begin
                w_req = 1'b1;
                if (imem_gnt) begin
                    w_adv       = ~flush;
                    w_stateNext = flush ? DROP : WAIT;
                end else if (flush) begin
                    w_stateNext = IDLE;
                end
            end
            WAIT: begin
                if (flush) begin
                    w_stateNext = imem_rvalid ? IDLE : DROP;
                end else if (imem_rvalid) begin
                    w_push      = 1'b1;
                    w_stateNext = w_slotAfterPush ? REQ : IDLE;
                end
            end
            DROP: begin
                if (imem_rvalid) begin
                    w_stateNext = IDLE;
                end
            end
            default: w_stateNext = IDLE;
        endcase
    end

    // State register and the tag of the request currently in flight.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_state <= IDLE;
            r_tag   <= 32'h0;
        end else begin
            r_state <= w_stateNext;
            if (r_state == REQ && imem_gnt) begin
                r_tag <= pc;
            end
        end
    end

    // Instruction buffer pointers and occupancy; a flush empties it outright.
    always_ff @(posedge clk) begin
        if (clr || flush) begin
            r_wrPtr <= 1'b0;
            r_rdPtr <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_push) begin
                r_wrPtr <= ~r_wrPtr;
            end
            if (w_pop) begin
                r_rdPtr <= ~r_rdPtr;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    // Buffer storage; contents are only visible through the valid-gated head.
    always_ff @(posedge clk) begin
        if (w_push && !flush && !clr) begin
            r_instMem[r_wrPtr] <= w_pushInst;
            r_pcMem[r_wrPtr]   <= w_pushPc;
        end
    end

`ifdef IF_ALIGN_CHK_EN
    // Address-error flag storage alongside each buffered entry.
    always_ff @(posedge clk) begin
        if (w_push && !flush && !clr) begin
            r_adelMem[r_wrPtr] <= w_pushAdel;
        end
    end

    // Once an address error is queued, fetching stops until a redirect.
    always_ff @(posedge clk) begin
        if (clr || flush) begin
            r_adelHalt <= 1'b0;
        end else if (w_push && w_pushAdel) begin
            r_adelHalt <= 1'b1;
        end
    end
`endif

endmodule

// File: doc/ifetch_unit.md
IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 Ports: clk, clr, pc, pc_adv, flush, imem_req, imem_addr, imem_gnt, imem_rvalid, imem_rdata, inst_valid, inst_ready, inst, inst_pc, fetch_adel.
REQ-002 The block SHALL have one clock domain; reset is synchronous and active-high.
REQ-003 The port list SHALL be:
- clk  in  1  clock, all state updates on rising edge.
- clr  in  1  synchronous active-high reset.
- pc  in  32  current virtual PC, held constant until pc_adv.
- pc_adv  out  1  one-cycle pulse; the PC register loads its next value (drives its enable).
- flush  in  1  redirect (branch, exception, eret); discards all fetched and in-flight instructions.
- imem_req  out  1  instruction memory request.
- imem_addr  out  32  request address.
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  read data valid; one response per granted request, in order, at least 1 cycle after gnt.
- imem_rdata  in  32  instruction word.
- inst_valid  out  1  inst and inst_pc valid toward decode.
- inst_ready  in  1  decode accepts this cycle.
- inst  out  32  instruction word.
- inst_pc  out  32  address of inst.
- fetch_adel  out  1  address-error-on-fetch flag paired with inst_valid (only with IF_ALIGN_CHK_EN).

Function
REQ-004 The FSM SHALL have states IDLE, REQ, WAIT and DROP.
REQ-005 IDLE->REQ when the buffer has at least one free slot and flush=0; imem_req=1 and imem_addr=pc only in REQ.
REQ-006 In REQ with imem_gnt=1, the block SHALL pulse pc_adv for exactly that cycle, latch pc as the pending tag, and go to WAIT; imem_req SHALL stay high, with a stable address, until gnt.
REQ-007 In WAIT with imem_rvalid=1, the block SHALL write {imem_rdata, tag} into the buffer. It then goes to REQ if a slot remains free after the write (zero-bubble back-to-back fetch), else IDLE.
REQ-008 At most one request SHALL be outstanding (granted, response not yet received).
REQ-009 The buffer SHALL be a 2-entry FIFO of {inst, inst_pc, adel}; inst_valid = not empty; the head is presented combinationally.
REQ-010 A pop SHALL occur when inst_valid & inst_ready. A push and a pop in the same cycle SHALL be allowed when full, with count unchanged.
REQ-011 A request SHALL NOT be issued if the buffer plus the outstanding slot would exceed 2 entries.
REQ-012 Pointers SHALL wrap modulo 2; count range is 0..2; overflow and underflow SHALL never occur.
REQ-013 flush SHALL clear the buffer in that cycle (inst_valid=0 next cycle). With flush, pc_adv SHALL be suppressed even if gnt is high.
REQ-014 Flush transitions SHALL be:
- REQ with gnt=0: the block goes to IDLE and drops the request.
- REQ with gnt=1, or WAIT: the block goes to DROP.
- DROP: the block discards the next imem_rvalid, then goes to IDLE; a response arriving in the flush cycle itself is discarded.
REQ-015 flush has priority over a same-cycle push; a pop in the flush cycle is still a valid handoff.
REQ-016 After a flush, the first request SHALL use the pc value present at issue time (the redirected PC).

Reset
REQ-017 On clr=1 at a rising edge, the block SHALL set state=IDLE, buffer empty and pending tag=0.
REQ-018 The output reset values SHALL be imem_req=0, pc_adv=0, inst_valid=0, fetch_adel=0, imem_addr=pc, and inst/inst_pc=0.
REQ-019 After reset with an outstanding request, a late imem_rvalid SHALL be ignored until the next gnt; the memory side is reset with the block.

Configuration
REQ-020 The macro IF_ALIGN_CHK_EN SHALL control alignment checking, as follows.
- Defined: if pc[1:0]!=0 in IDLE with a free slot, no imem_req is issued. An entry {inst=32'h0, inst_pc=pc, adel=1} is pushed, pc_adv is not pulsed, and no further fetch occurs until flush.
- Not defined: pc[1:0] is ignored, imem_addr={pc[31:2],2'b00}, and fetch_adel is tied to 0.

Verification
REQ-021 The bench SHALL cover these scenarios:
- Reset, pc=32'h8000_0000, gnt same cycle, rvalid 1 cycle later, inst_ready=1 -> inst_valid with inst_pc=32'h8000_0000; one pc_adv pulse per fetch.
- inst_ready=0 with 3 words available -> exactly 2 buffered; no imem_req while full+outstanding; releasing ready drains them in order with no loss or duplicate.
- Flush in WAIT, then rvalid arrives with 32'hDEAD_BEEF -> word discarded, inst_valid stays 0; next request addr = new pc 32'h8000_0180.
- gnt held low 5 cycles -> imem_req and imem_addr stable throughout, pc_adv=0 until gnt.
- clr asserted in WAIT -> state IDLE, inst_valid=0 next cycle, stray rvalid ignored.
- IF_ALIGN_CHK_EN defined, pc=32'h8000_0002 -> no imem_req; inst_valid=1, fetch_adel=1, inst_pc=32'h8000_0002.
